// File: rtl/rocketcpu_uart_wb_master.sv
// UART-to-Wishbone debug bridge: 'W'/'R' command frames on ser_rx start one Wishbone cycle,
// and the response goes back on ser_tx. Defining ROCKETCPU_UARTBRIDGE_TIMEOUT_EN adds a bus timeout.
module rocketcpu_uart_wb_master #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic        i_wb_clk,
    input  logic        resetn,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("rocketcpu_uart_wb_master: CLKS_PER_BIT must be >= 4 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_e;

    logic          rx_meta_q, rx_sync_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

    logic          tx_busy_q, tx_busy_d, tx_line_q, tx_line_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [8:0]    tx_shift_q, tx_shift_d;
    logic          tx_load;
    logic [7:0]    tx_byte;

    state_e        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic          cmd_we_q, cmd_we_d;
    logic [31:0]   adr_q, adr_d, dat_q, dat_d, resp_q, resp_d;
    logic          cyc_q, cyc_d, we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [2:0]    resp_left_q, resp_left_d;

    // Receiver: start edge re-checked at mid-bit, then data and stop sampled at bit centres.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_valid_d = rx_sync_q;
                rx_ferr_d  = !rx_sync_q;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        if (tx_load) begin
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = {1'b1, tx_byte};
            tx_line_d  = 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                end else begin
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

`ifdef ROCKETCPU_UARTBRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = (state_q == S_BUS) ? to_cnt_q + 1'b1 : '0;
    end
`endif

    // Wishbone request (adr/dat/we/sel) is valid and held stable while o_wb_cyc is high; the transfer
    // completes on the edge where i_wb_ack is sampled high, and cyc drops on that same edge.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        cmd_we_d    = cmd_we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        tx_load     = 1'b0;
        tx_byte     = resp_q[31:24];
        case (state_q)
            S_IDLE: if (rx_valid_q && (rx_shift_q == 8'h57 || rx_shift_q == 8'h52)) begin
                state_d    = S_ADDR;
                byte_cnt_d = 2'd0;
                cmd_we_d   = (rx_shift_q == 8'h57);
            end
            S_ADDR: if (rx_ferr_q) begin
                state_d = S_IDLE;
            end else if (rx_valid_q) begin
                adr_d      = {adr_q[23:0], rx_shift_q};
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    if (cmd_we_q) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        sel_d   = 4'hF;
                    end
                end
            end
            S_DATA: if (rx_ferr_q) begin
                state_d = S_IDLE;
            end else if (rx_valid_q) begin
                dat_d      = {dat_q[23:0], rx_shift_q};
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    state_d = S_BUS;
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    sel_d   = 4'hF;
                end
            end
            S_BUS: begin
                if (cyc_q && i_wb_ack) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'h0;
                    state_d = S_RESP;
                    if (cmd_we_q) begin
                        resp_d      = {8'h4B, 24'h0};
                        resp_left_d = 3'd1;
                    end else begin
                        resp_d      = i_wb_rdt;
                        resp_left_d = 3'd4;
                    end
                end
`ifdef ROCKETCPU_UARTBRIDGE_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'h0;
                    state_d     = S_RESP;
                    resp_d      = {8'h45, 24'h0};
                    resp_left_d = 3'd1;
                end
`endif
            end
            S_RESP: if (!tx_busy_q) begin
                if (resp_left_q != 3'd0) begin
                    tx_load     = 1'b1;
                    resp_d      = {resp_q[23:0], 8'h00};
                    resp_left_d = resp_left_q - 3'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (!resetn) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_valid_q  <= 1'b0;
            rx_ferr_q   <= 1'b0;
            tx_busy_q   <= 1'b0;
            tx_line_q   <= 1'b1;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '1;
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            cmd_we_q    <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            resp_q      <= '0;
            resp_left_q <= '0;
`ifdef ROCKETCPU_UARTBRIDGE_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            rx_meta_q   <= ser_rx;
            rx_sync_q   <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_valid_q  <= rx_valid_d;
            rx_ferr_q   <= rx_ferr_d;
            tx_busy_q   <= tx_busy_d;
            tx_line_q   <= tx_line_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            cmd_we_q    <= cmd_we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
`ifdef ROCKETCPU_UARTBRIDGE_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign ser_tx   = tx_line_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = sel_q;
    assign o_wb_we  = we_q;
    assign o_wb_cyc = cyc_q;
endmodule

// File: tb/tb_rocketcpu_uart_wb_master.sv
// Directed bench for rocketcpu_uart_wb_master: UART frames in, Wishbone slave model, TX byte decoder.
module tb_rocketcpu_uart_wb_master;
    localparam int CPB    = 8;
    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ser_rx = 1'b1;
    logic        ser_tx;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc;
    logic [31:0] i_wb_rdt = 32'h0;
    logic        i_wb_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    bit          ack_en = 1'b1;
    int          ack_delay = 3;
    logic [31:0] slave_rdt = 32'h0;
    bit          spur_req = 1'b0;
    int          txn_count = 0;
    int          cyc_run = 0;
    int          cyc_width = 0;
    logic [31:0] seen_adr = 32'h0, seen_dat = 32'h0;
    logic        seen_we = 1'b0;
    logic [3:0]  seen_sel = 4'h0;
    logic [7:0]  mon_b;

    rocketcpu_uart_wb_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TO_CYC)) dut (
        .i_wb_clk(clk), .resetn(resetn), .ser_rx(ser_rx), .ser_tx(ser_tx),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack)
    );

    // clock / watchdog
    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Wishbone slave: acks on the ack_delay-th cycle cyc is seen high, records the request.
    initial begin
        forever begin
            @(negedge clk);
            i_wb_ack = 1'b0;
            if (o_wb_cyc === 1'b1) begin
                cyc_run++;
                if (ack_en && cyc_run == ack_delay) begin
                    i_wb_ack  = 1'b1;
                    i_wb_rdt  = slave_rdt;
                    seen_adr  = o_wb_adr;
                    seen_dat  = o_wb_dat;
                    seen_we   = o_wb_we;
                    seen_sel  = o_wb_sel;
                    txn_count++;
                end
            end else begin
                if (cyc_run != 0) cyc_width = cyc_run;
                cyc_run = 0;
                if (spur_req) begin
                    i_wb_ack = 1'b1;
                    spur_req = 1'b0;
                end
            end
        end
    end

    // TX decoder: pushes every correctly framed byte seen on ser_tx.
    initial begin
        forever begin
            @(negedge clk);
            if (ser_tx === 1'b0) begin
                repeat (CPB / 2 - 1) @(negedge clk);
                if (ser_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        mon_b[i] = ser_tx;
                    end
                    repeat (CPB) @(negedge clk);
                    if (ser_tx === 1'b1) tx_q.push_back(mon_b);
                end
            end
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        ser_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        ser_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        ser_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_read(input logic [31:0] adr);
        send_byte(8'h52, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8], 1'b1);
    endtask

    task automatic send_write(input logic [31:0] adr, input logic [31:0] dat);
        send_byte(8'h57, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8], 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8], 1'b1);
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (tx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (4 * CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++; if (ser_tx !== 1'b1) begin n_fail++; $display("FAIL reset_ser_tx: got %b want 1", ser_tx); end
        n_checks++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %b want 0", o_wb_cyc); end
        n_checks++; if (o_wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", o_wb_we); end
        n_checks++; if (o_wb_sel !== 4'h0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", o_wb_sel); end
        n_checks++; if (o_wb_adr !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", o_wb_adr); end
        n_checks++; if (o_wb_dat !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", o_wb_dat); end
    endtask

    task automatic test_write();
        int base;
        bit ok;
        base = txn_count;
        ack_en = 1'b1; ack_delay = 3;
        tx_q.delete();
        send_write(32'h0000_1004, 32'hDEAD_BEEF);
        wait_tx(1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL write_tx_wait: got %0d bytes want 1", tx_q.size()); end
        n_checks++; if (txn_count !== base + 1) begin n_fail++; $display("FAIL write_txn: got %0d want %0d", txn_count, base + 1); end
        n_checks++; if (seen_adr !== 32'h0000_1004) begin n_fail++; $display("FAIL write_adr: got %h want 00001004", seen_adr); end
        n_checks++; if (seen_dat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_dat: got %h want deadbeef", seen_dat); end
        n_checks++; if (seen_we !== 1'b1) begin n_fail++; $display("FAIL write_we: got %b want 1", seen_we); end
        n_checks++; if (seen_sel !== 4'hF) begin n_fail++; $display("FAIL write_sel: got %h want f", seen_sel); end
        n_checks++; if (cyc_width !== 3) begin n_fail++; $display("FAIL write_cyc_width: got %0d want 3", cyc_width); end
        n_checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin n_fail++; $display("FAIL write_resp: got %0d bytes first %h want 1 byte 4b", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
        n_checks++; if (o_wb_cyc !== 1'b0 || o_wb_we !== 1'b0 || o_wb_sel !== 4'h0) begin n_fail++; $display("FAIL write_idle_bus: got cyc=%b we=%b sel=%h want 0 0 0", o_wb_cyc, o_wb_we, o_wb_sel); end
    endtask

    task automatic test_read();
        bit ok;
        ack_en = 1'b1; ack_delay = 2;
        slave_rdt = 32'h1234_5678;
        tx_q.delete();
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_read(32'h0000_2000);
        wait_tx(4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL read_tx_wait: got %0d bytes want 4", tx_q.size()); end
        n_checks++; if (seen_adr !== 32'h0000_2000) begin n_fail++; $display("FAIL read_adr: got %h want 00002000", seen_adr); end
        n_checks++; if (seen_we !== 1'b0) begin n_fail++; $display("FAIL read_we: got %b want 0", seen_we); end
        n_checks++; if (seen_sel !== 4'hF) begin n_fail++; $display("FAIL read_sel: got %h want f", seen_sel); end
        n_checks++; if (tx_q.size() != 4) begin n_fail++; $display("FAIL read_resp_len: got %0d want 4", tx_q.size()); end
        for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
            n_checks++; if (tx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL read_resp_byte%0d: got %h want %h", i, tx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ignore_byte();
        int base;
        bit ok;
        base = txn_count;
        ack_en = 1'b1; ack_delay = 1;
        slave_rdt = 32'hA5A5_0F0F;
        tx_q.delete();
        exp_q = '{8'hA5, 8'hA5, 8'h0F, 8'h0F};
        send_byte(8'h41, 1'b1);
        repeat (4 * CPB) @(negedge clk);
        n_checks++; if (txn_count !== base || o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL ignore_no_cycle: got txn=%0d cyc=%b want %0d 0", txn_count, o_wb_cyc, base); end
        send_read(32'h0000_0040);
        wait_tx(4, ok);
        n_checks++; if (txn_count !== base + 1) begin n_fail++; $display("FAIL ignore_txn: got %0d want %0d", txn_count, base + 1); end
        n_checks++; if (seen_adr !== 32'h0000_0040) begin n_fail++; $display("FAIL ignore_adr: got %h want 00000040", seen_adr); end
        n_checks++; if (cyc_width !== 1) begin n_fail++; $display("FAIL ignore_min_cyc_width: got %0d want 1", cyc_width); end
        n_checks++; if (tx_q.size() != 4) begin n_fail++; $display("FAIL ignore_resp_len: got %0d want 4", tx_q.size()); end
        for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
            n_checks++; if (tx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ignore_resp_byte%0d: got %h want %h", i, tx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_framing_error();
        int base;
        bit ok;
        base = txn_count;
        ack_en = 1'b1; ack_delay = 2;
        slave_rdt = 32'hCAFE_F00D;
        tx_q.delete();
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b0);
        repeat (15 * CPB) @(negedge clk);
        n_checks++; if (txn_count !== base || tx_q.size() != 0) begin n_fail++; $display("FAIL ferr_no_cycle: got txn=%0d tx=%0d want %0d 0", txn_count, tx_q.size(), base); end
        exp_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        send_read(32'h0000_3000);
        wait_tx(4, ok);
        n_checks++; if (txn_count !== base + 1) begin n_fail++; $display("FAIL ferr_next_txn: got %0d want %0d", txn_count, base + 1); end
        n_checks++; if (seen_adr !== 32'h0000_3000 || seen_we !== 1'b0) begin n_fail++; $display("FAIL ferr_next_req: got adr=%h we=%b want 00003000 0", seen_adr, seen_we); end
        n_checks++; if (tx_q.size() != 4) begin n_fail++; $display("FAIL ferr_next_len: got %0d want 4", tx_q.size()); end
        for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
            n_checks++; if (tx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ferr_next_byte%0d: got %h want %h", i, tx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_spurious_ack();
        int base;
        base = txn_count;
        tx_q.delete();
        spur_req = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL spur_cyc: got %b want 0", o_wb_cyc); end
        repeat (12 * CPB) @(negedge clk);
        n_checks++; if (tx_q.size() != 0 || txn_count !== base) begin n_fail++; $display("FAIL spur_no_resp: got tx=%0d txn=%0d want 0 %0d", tx_q.size(), txn_count, base); end
    endtask

`ifdef ROCKETCPU_UARTBRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int base;
        bit ok;
        base = txn_count;
        ack_en = 1'b0;
        tx_q.delete();
        send_read(32'h0000_5000);
        wait_tx(1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_tx_wait: got %0d bytes want 1", tx_q.size()); end
        n_checks++; if (cyc_width !== TO_CYC) begin n_fail++; $display("FAIL timeout_cyc_width: got %0d want %0d", cyc_width, TO_CYC); end
        n_checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h45) begin n_fail++; $display("FAIL timeout_resp: got %0d bytes first %h want 1 byte 45", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
        ack_en = 1'b1; ack_delay = 3;
        tx_q.delete();
        send_write(32'h0000_5004, 32'h0102_0304);
        wait_tx(1, ok);
        n_checks++; if (txn_count !== base + 1 || seen_dat !== 32'h0102_0304) begin n_fail++; $display("FAIL timeout_next: got txn=%0d dat=%h want %0d 01020304", txn_count, seen_dat, base + 1); end
        n_checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin n_fail++; $display("FAIL timeout_next_resp: got %0d bytes first %h want 1 byte 4b", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    endtask
`endif

    task automatic test_reset_mid();
        bit seen;
        int low_cnt, cyc_cnt;
        ack_en = 1'b0;
        send_read(32'h0000_6000);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (o_wb_cyc === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_cyc_rise: got cyc=0 want 1 within 200 cycles"); end
        resetn = 1'b0;
        @(negedge clk);
        n_checks++; if (o_wb_cyc !== 1'b0 || ser_tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_bus: got cyc=%b tx=%b want 0 1", o_wb_cyc, ser_tx); end
        n_checks++; if (o_wb_adr !== 32'h0 || o_wb_we !== 1'b0 || o_wb_sel !== 4'h0) begin n_fail++; $display("FAIL rstmid_outs: got adr=%h we=%b sel=%h want 0 0 0", o_wb_adr, o_wb_we, o_wb_sel); end
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        ack_en = 1'b1; ack_delay = 2;
        slave_rdt = 32'h0000_0000;
        send_read(32'h0000_7000);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (ser_tx === 1'b0) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_tx_start: got tx=1 want 0 within 300 cycles"); end
        repeat (3 * CPB) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        n_checks++; if (ser_tx !== 1'b1 || o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx: got tx=%b cyc=%b want 1 0", ser_tx, o_wb_cyc); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        tx_q.delete();
        low_cnt = 0; cyc_cnt = 0;
        for (int i = 0; i < 40 * CPB; i++) begin
            @(negedge clk);
            if (ser_tx !== 1'b1) low_cnt++;
            if (o_wb_cyc !== 1'b0) cyc_cnt++;
        end
        n_checks++; if (low_cnt != 0 || tx_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_resp: got low=%0d bytes=%0d want 0 0", low_cnt, tx_q.size()); end
        n_checks++; if (cyc_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_cycle: got %0d cyc cycles want 0", cyc_cnt); end
    endtask

    initial begin
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_ignore_byte();
        test_framing_error();
        test_spurious_ack();
`ifdef ROCKETCPU_UARTBRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
